// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration scan loader and tile-level chain sizing.
package cfg_pkg;

    localparam int unsigned CLB_IN_WIDTH   = 4;
    localparam int unsigned CONN_SEL_WIDTH = 3;

    // is_comb flag + one input-select field per LUT input + LUT truth table
    localparam int unsigned CLB_CHAIN_BITS = 1 + CONN_SEL_WIDTH * CLB_IN_WIDTH + 2 ** CLB_IN_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } cfg_state_e;

endpackage

// File: rtl/cfg_piso.sv
// Parallel-load / serial-out word register; bit 0 leaves first.
module cfg_piso #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned WB_WIDTH   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [WORD_WIDTH-1:0] data,
    output logic                  sout,
    output logic [WB_WIDTH-1:0]   word_bit
);

    logic [WORD_WIDTH-1:0] word_q;
    logic [WB_WIDTH-1:0]   word_bit_q;

    // A load wins over a shift so the prefetched word replaces the spent one seamlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            word_bit_q <= '0;
        end else if (load) begin
            word_q     <= data;
            word_bit_q <= '0;
        end else if (shift) begin
            word_q     <= word_q >> 1;
            word_bit_q <= word_bit_q + WB_WIDTH'(1);
        end
    end

    assign sout     = word_q[0];
    assign word_bit = word_bit_q;

endmodule

// File: rtl/cfg_scan_loader.sv
// Serialises configuration words LSB-first onto a CLB scan chain and counts CHAIN_LEN bits.
module cfg_scan_loader
    import cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN  = CLB_CHAIN_BITS,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  scan_out,
    output logic                  scan_en,
    input  logic                  scan_ret,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  bit_cnt,
    output logic                  ret_last
);

    localparam int unsigned WB_WIDTH = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CHAIN_LEN - 1);
    localparam logic [WB_WIDTH-1:0]  LAST_WB  = WB_WIDTH'(WORD_WIDTH - 1);

    cfg_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic                 ret_last_q, ret_last_d;

    logic                 piso_load;
    logic                 piso_shift;
    logic                 piso_sout;
    logic [WB_WIDTH-1:0]  word_bit;
    logic                 last_chain_bit;
    logic                 last_word_bit;

    cfg_piso #(
        .WORD_WIDTH (WORD_WIDTH),
        .WB_WIDTH   (WB_WIDTH)
    ) u_piso (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (piso_load),
        .shift    (piso_shift),
        .data     (cfg_data),
        .sout     (piso_sout),
        .word_bit (word_bit)
    );

    assign last_chain_bit = (bit_cnt_q == LAST_CNT);
    assign last_word_bit  = (word_bit == LAST_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            ret_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ret_last_q <= ret_last_d;
        end
    end

    // cfg_ready is a function of state and counters only, never of cfg_valid.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ret_last_d = ret_last_q;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        cfg_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoad;
                    bit_cnt_d = '0;
                end
            end
            StLoad: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    piso_load = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                piso_shift = 1'b1;
                bit_cnt_d  = bit_cnt_q + CNT_WIDTH'(1);
                if (last_chain_bit) begin
                    ret_last_d = scan_ret;
                    state_d    = StDone;
                end else if (last_word_bit) begin
                    // Prefetch the next word so bits stream with no bubble.
                    cfg_ready = 1'b1;
                    if (cfg_valid) begin
                        piso_load = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                if (start) begin
                    state_d   = StLoad;
                    bit_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign scan_en  = (state_q == StShift);
    assign scan_out = scan_en & piso_sout;
    assign busy     = (state_q == StLoad) || (state_q == StShift);
    assign done     = (state_q == StDone);
    assign bit_cnt  = bit_cnt_q;
    assign ret_last = ret_last_q;

endmodule

// File: tb/tb_cfg_scan_loader.sv
// Bench for cfg_scan_loader: bit-queue model checked every cycle plus hand-computed load results.
module tb_cfg_scan_loader;

    localparam int CHAIN_LEN  = 29;
    localparam int WORD_WIDTH = 8;
    localparam int CNT_WIDTH  = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [WORD_WIDTH-1:0] cfg_data;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic                  scan_out;
    logic                  scan_en;
    logic                  scan_ret;
    logic                  busy;
    logic                  done;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic                  ret_last;

    // Model of the downstream chain: chain[0] is the tail, new bits enter at the head.
    logic [CHAIN_LEN-1:0] chain = '0;

    int total = 0;
    int bad   = 0;

    int                   en_cnt, ready_cnt, acc_cnt, gap_cnt;
    logic                 seen_en;
    logic [CHAIN_LEN-1:0] collected;

    // Abstract model: queue of accepted bits still owed to the chain.
    logic m_loading, m_done, m_ret;
    int   m_cnt, m_pushed, n_take;
    logic mq[$];
    logic e_busy, e_en, e_out, e_rdy;

    always #5 clk = ~clk;

    cfg_scan_loader #(
        .CHAIN_LEN  (CHAIN_LEN),
        .WORD_WIDTH (WORD_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .scan_out  (scan_out),
        .scan_en   (scan_en),
        .scan_ret  (scan_ret),
        .busy      (busy),
        .done      (done),
        .bit_cnt   (bit_cnt),
        .ret_last  (ret_last)
    );

    assign scan_ret = chain[0];

    always @(posedge clk) begin
        if (scan_en) chain <= {scan_out, chain[CHAIN_LEN-1:1]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_loading = 1'b0;
            m_done    = 1'b0;
            m_ret     = 1'b0;
            m_cnt     = 0;
            m_pushed  = 0;
            mq.delete();
        end else begin
            e_busy = m_loading;
            e_en   = m_loading && (mq.size() > 0);
            e_out  = 1'b0;
            if (e_en) e_out = mq[0];
            e_rdy  = m_loading && ((mq.size() == 0) ||
                                   ((mq.size() == 1) && (m_cnt < CHAIN_LEN - 1)));
            chk("cyc_scan_en",  32'(scan_en),   32'(e_en));
            chk("cyc_scan_out", 32'(scan_out),  32'(e_out));
            chk("cyc_busy",     32'(busy),      32'(e_busy));
            chk("cyc_done",     32'(done),      32'(m_done));
            chk("cyc_bit_cnt",  32'(bit_cnt),   32'(m_cnt));
            chk("cyc_cfg_ready", 32'(cfg_ready), 32'(e_rdy));
            chk("cyc_ret_last", 32'(ret_last),  32'(m_ret));

            if (scan_en) begin
                if (en_cnt < CHAIN_LEN) collected[en_cnt] = scan_out;
                en_cnt++;
                seen_en = 1'b1;
            end else if (seen_en && busy) begin
                gap_cnt++;
            end
            if (busy && cfg_ready) ready_cnt++;
            if (cfg_valid && cfg_ready) acc_cnt++;

            if (e_en) begin
                void'(mq.pop_front());
                m_cnt++;
                if (m_cnt == CHAIN_LEN) begin
                    m_ret     = scan_ret;
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end
            end
            if (cfg_valid && e_rdy) begin
                n_take = (CHAIN_LEN - m_pushed < WORD_WIDTH) ? CHAIN_LEN - m_pushed : WORD_WIDTH;
                for (int k = 0; k < n_take; k++) mq.push_back(cfg_data[k]);
                m_pushed += n_take;
            end
            if (start && !e_busy) begin
                m_loading = 1'b1;
                m_done    = 1'b0;
                m_cnt     = 0;
                m_pushed  = 0;
                mq.delete();
            end
        end
    end

    task automatic do_start();
        en_cnt    = 0;
        ready_cnt = 0;
        acc_cnt   = 0;
        gap_cnt   = 0;
        seen_en   = 1'b0;
        collected = '0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy",    32'(busy),      32'd1);
        chk("start_done",    32'(done),      32'd0);
        chk("start_ready",   32'(cfg_ready), 32'd1);
        chk("start_bit_cnt", 32'(bit_cnt),   32'd0);
    endtask

    task automatic send_words(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                              input logic [7:0] w3, input int low_after_first,
                              input bit start_in_shift);
        logic [7:0] w[4];
        int i     = 0;
        int hold  = 0;
        int guard = 0;
        bit hs;
        bit poke  = 1'b0;
        w = '{w0, w1, w2, w3};
        while (i < 4 && guard < 400) begin
            start = poke;
            poke  = 1'b0;
            if (hold > 0) begin
                cfg_valid = 1'b0;
                hold--;
            end else begin
                cfg_valid = 1'b1;
                cfg_data  = w[i];
            end
            @(negedge clk);
            hs = cfg_valid && cfg_ready;
            @(posedge clk);
            #1;
            guard++;
            if (hs) begin
                i++;
                if (i == 1) begin
                    hold = low_after_first;
                    poke = start_in_shift;
                end
            end
        end
        start     = 1'b0;
        cfg_valid = 1'b0;
        if (i < 4) chk("words_sent_timeout", 32'(i), 32'd4);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        en_cnt    = 0;
        ready_cnt = 0;
        acc_cnt   = 0;
        gap_cnt   = 0;
        seen_en   = 1'b0;
        collected = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scan_en",  32'(scan_en),   32'd0);
        chk("rst_scan_out", 32'(scan_out),  32'd0);
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_done",     32'(done),      32'd0);
        chk("rst_ready",    32'(cfg_ready), 32'd0);
        chk("rst_bit_cnt",  32'(bit_cnt),   32'd0);
        chk("rst_ret_last", 32'(ret_last),  32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // Nominal load, source always valid: stream is 0x01FF3CA5 LSB-first, truncated to 29 bits.
        do_start();
        send_words(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, 1'b0);
        wait_done();
        chk("nom_en_cycles", 32'(en_cnt),    32'd29);
        chk("nom_ready_cyc", 32'(ready_cnt), 32'd4);
        chk("nom_accepted",  32'(acc_cnt),   32'd4);
        chk("nom_gap",       32'(gap_cnt),   32'd0);
        chk("nom_bit_cnt",   32'(bit_cnt),   32'd29);
        chk("nom_stream",    32'(collected), 32'h01FF3CA5);
        chk("nom_chain",     32'(chain),     32'h01FF3CA5);
        chk("nom_ret_last",  32'(ret_last),  32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("nom_done_held", 32'(done),    32'd1);
        chk("nom_cnt_held",  32'(bit_cnt), 32'd29);

        // Restart from DONE; source stalls 5 cycles past the first word boundary, start poked in SHIFT.
        do_start();
        send_words(8'h5A, 8'hC3, 8'h0F, 8'h1E, 13, 1'b1);
        wait_done();
        chk("stall_en_cycles", 32'(en_cnt),    32'd29);
        chk("stall_gap",       32'(gap_cnt),   32'd6);
        chk("stall_accepted",  32'(acc_cnt),   32'd4);
        chk("stall_stream",    32'(collected), 32'h1E0FC35A);
        chk("stall_chain",     32'(chain),     32'h1E0FC35A);
        // Final shift sees the previous load's head bit (bit 28 of 0x01FF3CA5) at the tail.
        chk("stall_ret_last",  32'(ret_last),  32'd0);

        // Reload with zeros: the last bit returned is bit 28 of 0x1E0FC35A.
        do_start();
        send_words(8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        wait_done();
        chk("loop_ret_last", 32'(ret_last), 32'd1);
        chk("loop_chain",    32'(chain),    32'd0);
        chk("loop_en",       32'(en_cnt),   32'd29);

        // Asynchronous reset in the middle of a shift.
        do_start();
        cfg_data  = 8'hAA;
        cfg_valid = 1'b1;
        guard     = 0;
        while (en_cnt < 10 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("mid_reach_bit10", 32'(en_cnt >= 10), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_scan_en",  32'(scan_en),   32'd0);
        chk("mid_done",     32'(done),      32'd0);
        chk("mid_bit_cnt",  32'(bit_cnt),   32'd0);
        chk("mid_busy",     32'(busy),      32'd0);
        chk("mid_ready",    32'(cfg_ready), 32'd0);
        chk("mid_ret_last", 32'(ret_last),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_busy",    32'(busy),      32'd0);
        chk("post_ready",   32'(cfg_ready), 32'd0);
        chk("post_scan_en", 32'(scan_en),   32'd0);
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
